// File: rtl/dll_lock_sequencer.sv
// Reset/lock sequencer for the internal and external 2X clock DLL pair, clocked by the board clock.
// Optional build macro LOCK_LOSS_RECOVERY_EN: re-sequence the DLLs after a sustained lock loss in RUN.
module dll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned STABLE_CYCLES    = 1024,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned CNT_W            = 17
) (
    input  logic       ui_board_clk,
    input  logic       ui_reset_n,
    input  logic       locked_int,
    input  logic       locked_ext,
    output logic       dll_rst,
    output logic       sys_reset_n,
    output logic       clk_ready,
    output logic       lock_fail,
    output logic [3:0] retry_count,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET_DLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [3:0]       retry_r, retry_next_s;
    logic [2:0]       state_o_next_s;
    logic             li_meta_r, li_sync_r, le_meta_r, le_sync_r;
    logic             both_s;
    // flag_r: pending-drop marker with recovery enabled, sticky lock_lost otherwise
    logic             flag_r, flag_next_s;

    assign both_s      = li_sync_r & le_sync_r;
    assign retry_count = retry_r;

    // Two-flop synchronisers for the asynchronous LOCKED inputs
    always_ff @(posedge ui_board_clk) begin
        if (!ui_reset_n) begin
            li_meta_r <= 1'b0;
            li_sync_r <= 1'b0;
            le_meta_r <= 1'b0;
            le_sync_r <= 1'b0;
        end else begin
            li_meta_r <= locked_int;
            li_sync_r <= li_meta_r;
            le_meta_r <= locked_ext;
            le_sync_r <= le_meta_r;
        end
    end

    // Next-state, counter, retry and debug-encoding logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + CNT_ONE;
        retry_next_s = retry_r;
        flag_next_s  = 1'b0;
        case (state_r)
            ST_RESET_DLL: begin
                if (cnt_r == RST_LAST) begin
                    state_next_s = ST_WAIT_LOCK;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_RESET_DLL;
                end
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (both_s) begin
                    state_next_s = ST_STABLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (retry_r < RETRY_MAX) begin
                        retry_next_s = retry_r + 4'd1;
                        state_next_s = ST_RESET_DLL;
                    end else begin
                        state_next_s = ST_FAIL;
                    end
                end else begin
                    state_next_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!both_s) begin
                    state_next_s = ST_WAIT_LOCK;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                cnt_next_s = CNT_ZERO;
`ifdef LOCK_LOSS_RECOVERY_EN
                if (!both_s && flag_r) begin
                    state_next_s = ST_RESET_DLL;
                    retry_next_s = 4'd0;
                    flag_next_s  = 1'b0;
                end else if (!both_s) begin
                    flag_next_s = 1'b1;
                end else begin
                    flag_next_s = 1'b0;
                end
`else
                flag_next_s = flag_r | ~both_s;
`endif
            end
            ST_FAIL: begin
                cnt_next_s = CNT_ZERO;
            end
            default: begin
                state_next_s = ST_RESET_DLL;
                cnt_next_s   = CNT_ZERO;
            end
        endcase

`ifdef LOCK_LOSS_RECOVERY_EN
        state_o_next_s = state_next_s;
`else
        if ((state_next_s == ST_RUN) && flag_next_s) begin
            state_o_next_s = 3'b111;
        end else begin
            state_o_next_s = state_next_s;
        end
`endif
    end

    // State, counter and registered outputs; outputs follow the next state so they align with it
    always_ff @(posedge ui_board_clk) begin
        if (!ui_reset_n) begin
            state_r     <= ST_RESET_DLL;
            cnt_r       <= CNT_ZERO;
            retry_r     <= 4'd0;
            flag_r      <= 1'b0;
            dll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            clk_ready   <= 1'b0;
            lock_fail   <= 1'b0;
            state_o     <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            retry_r     <= retry_next_s;
            flag_r      <= flag_next_s;
            dll_rst     <= (state_next_s == ST_RESET_DLL);
            sys_reset_n <= (state_next_s == ST_RUN);
            clk_ready   <= (state_next_s == ST_RUN);
            lock_fail   <= (state_next_s == ST_FAIL);
            state_o     <= state_o_next_s;
        end
    end

endmodule

// File: tb/tb_dll_lock_sequencer.sv
// Scoreboard bench for dll_lock_sequencer: scenario planner predicts output-change events, monitor checks them.
module tb_dll_lock_sequencer;

    localparam int RP = 8;
    localparam int TO = 50;
    localparam int ST = 16;
    localparam int MR = 3;

    typedef struct {
        int         t;
        logic [10:0] v;
    } ev_t;

    logic       clk = 1'b0;
    logic       ui_reset_n, locked_int, locked_ext;
    logic       dll_rst, sys_reset_n, clk_ready, lock_fail;
    logic [3:0] retry_count;
    logic [2:0] state_o;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          last_t = 0;
    bit          mon_en = 1'b0;
    logic [10:0] last_v;
    logic [10:0] prev_v;
    ev_t         exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dll_lock_sequencer #(
        .RST_PULSE_CYCLES(RP),
        .LOCK_TIMEOUT(TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES(MR),
        .CNT_W(17)
    ) dut (
        .ui_board_clk(clk),
        .ui_reset_n(ui_reset_n),
        .locked_int(locked_int),
        .locked_ext(locked_ext),
        .dll_rst(dll_rst),
        .sys_reset_n(sys_reset_n),
        .clk_ready(clk_ready),
        .lock_fail(lock_fail),
        .retry_count(retry_count),
        .state_o(state_o)
    );

    function automatic logic [10:0] mk(input logic [2:0] st, input logic dr, input logic sr,
                                       input logic rdy, input logic lf, input int rc);
        logic [3:0] r4;
        r4 = rc[3:0];
        return {st, dr, sr, rdy, lf, r4};
    endfunction

    function automatic logic [10:0] cur_vec();
        return {state_o, dll_rst, sys_reset_n, clk_ready, lock_fail, retry_count};
    endfunction

    // record an expected output value that becomes visible after edge t
    task automatic push_exp(input int t, input logic [10:0] v);
        if (v != last_v) begin
            exp_q.push_back('{t, v});
            last_v = v;
        end
        if (t > last_t) last_t = t;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: every change of the output bundle must match the next predicted event
    always @(negedge clk) begin
        logic [10:0] cur;
        ev_t e;
        cur = cur_vec();
        if (mon_en && (cur !== prev_v)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change t=%0d got=%h prev=%h", cyc, cur, prev_v);
            end else begin
                e = exp_q.pop_front();
                if ((e.t != cyc) || (e.v !== cur)) begin
                    bad++;
                    $display("FAIL event t=%0d got=%h expected t=%0d val=%h", cyc, cur, e.t, e.v);
                end
            end
        end
        prev_v = cur;
    end

    // kind: 0 random, 1 nominal, 2 forced fail, 3 stable glitch at count 10, 4 two-clock drop in RUN
    task automatic run_scenario(input int kind);
        int x, r, w, s, u, d, a, b, k, mode, m, rl, drop_len, tt;
        bit done;
        x = cyc;
        ui_reset_n = 1'b0;
        locked_int = 1'b0;
        locked_ext = 1'b0;
        rl = (kind != 0) ? 1 : int'($urandom_range(1, 2));
        push_exp(x + 1, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        wait_until(x + rl);
        ui_reset_n = 1'b1;
        r = x + rl;
        k = 0;
        done = 1'b0;
        while (!done) begin
            w = r + RP;
            push_exp(w, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, k));
            if (kind == 2) begin
                mode = 2 + (k % 2);
            end else if (kind != 0) begin
                mode = 0;
            end else begin
                m = $urandom_range(0, 99);
                mode = (m < 40) ? 0 : (m < 55) ? 1 : (m < 85) ? 2 : 3;
            end
            if (mode <= 1) begin
                d = (mode == 1) ? TO - 3 : int'($urandom_range(0, TO - 4));
                s = w + d + 3;
                push_exp(s, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, k));
                a = -1;
                if (kind == 3) a = 8;
                else if ((kind == 0) && ($urandom_range(0, 1) == 1)) a = $urandom_range(0, 13);
                if (a >= 0) begin
                    push_exp(s + a + 3, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, k));
                    push_exp(s + a + 4, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, k));
                    u = s + a + 4 + ST;
                end else begin
                    u = s + ST;
                end
                push_exp(u, mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, k));
                drop_len = (kind == 4) ? 2 : (kind == 0) ? int'($urandom_range(0, 2)) : 0;
                b = $urandom_range(0, 5);
`ifdef LOCK_LOSS_RECOVERY_EN
                if (drop_len == 2) begin
                    tt = u + b + 4;
                    push_exp(tt, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
                    push_exp(tt + RP, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
                    push_exp(tt + RP + 1, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0));
                    push_exp(tt + RP + 1 + ST, mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 0));
                end
`else
                tt = u + b + 3;
                if (drop_len > 0) push_exp(tt, mk(3'd7, 1'b0, 1'b1, 1'b1, 1'b0, k));
`endif
                wait_until(w + d);
                locked_int = 1'b1;
                locked_ext = 1'b1;
                if (a >= 0) begin
                    wait_until(s + a);
                    locked_int = 1'b0;
                    wait_until(s + a + 1);
                    locked_int = 1'b1;
                end
                if (drop_len > 0) begin
                    wait_until(u + b);
                    locked_ext = 1'b0;
                    wait_until(u + b + drop_len);
                    locked_ext = 1'b1;
                end
                done = 1'b1;
            end else begin
                if (k < MR) push_exp(w + TO, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, k + 1));
                else        push_exp(w + TO, mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, k));
                if (mode == 2) begin
                    d = $urandom_range(0, TO - 1);
                    wait_until(w + d);
                    locked_int = 1'b1;
                end else begin
                    wait_until(w + TO - 2);
                    locked_int = 1'b1;
                    locked_ext = 1'b1;
                end
                if (k < MR) begin
                    wait_until(w + TO);
                    locked_int = 1'b0;
                    locked_ext = 1'b0;
                    r = w + TO;
                    k++;
                end else begin
                    done = 1'b1;
                end
            end
        end
        wait_until(last_t + int'($urandom_range(3, 10)));
    endtask

    initial begin
        ui_reset_n = 1'b0;
        locked_int = 1'b0;
        locked_ext = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (cur_vec() !== mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL reset_state got=%h expected=%h", cur_vec(), mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        end
        last_v = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        run_scenario(1);
        run_scenario(2);
        run_scenario(3);
        run_scenario(4);
        run_scenario(2);
        run_scenario(1);
        repeat (20) run_scenario(0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d expected completion", cyc);
        $fatal(1);
    end

endmodule
